// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXE/MEM/WB sequencing, control decode, retired-instruction count.
// Optional MC_CTRL_MEM_WAIT_EN: MEM holds until mem_ready=1; without it MEM is always a single cycle.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             mem_wr,
  output logic             ext_op,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [1:0]       npc_op,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t cur, nxt;
  logic   retire;

  logic is_r, is_add, is_sub, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal, supported;

  // funct 000000 is accepted so the all-zero nop word behaves as add $0
  assign is_r      = (opcode == 6'b000000);
  assign is_add    = is_r && (funct == 6'b100000 || funct == 6'b000000);
  assign is_sub    = is_r && (funct == 6'b100010);
  assign is_jr     = is_r && (funct == 6'b001000);
  assign is_ori    = (opcode == 6'b001101);
  assign is_lw     = (opcode == 6'b100011);
  assign is_sw     = (opcode == 6'b101011);
  assign is_beq    = (opcode == 6'b000100);
  assign is_lui    = (opcode == 6'b001111);
  assign is_jal    = (opcode == 6'b000011);
  assign supported = is_add | is_sub | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_jal;

  assign state = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= FETCH;
      instr_cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt    = FETCH;
    retire = 1'b0;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        if (!supported) begin
          nxt    = FETCH;
          retire = 1'b1;
        end else if (is_jal) begin
          nxt = WB;
        end else begin
          nxt = EXE;
        end
      end
      EXE: begin
        if (is_lw || is_sw) begin
          nxt = MEM;
        end else if (is_beq || is_jr) begin
          nxt    = FETCH;
          retire = 1'b1;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
`ifdef MC_CTRL_MEM_WAIT_EN
        if (!mem_ready) begin
          nxt = MEM;
        end else
`endif
        if (is_sw) begin
          nxt    = FETCH;
          retire = 1'b1;
        end else begin
          nxt = WB;
        end
      end
      WB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    ext_op  = 1'b0;
    alu_src = 1'b0;
    alu_op  = 3'd0;
    reg_dst = 2'd0;
    wd_sel  = 2'd0;
    npc_op  = 2'd0;
    illegal = 1'b0;

    // Selects stay fixed from DECODE through WB so the extender and ALU inputs are stable
    if (cur == DECODE || cur == EXE || cur == MEM || cur == WB) begin
      ext_op  = is_lw | is_sw | is_beq;
      alu_src = is_ori | is_lw | is_sw | is_lui;
      if (is_sub || is_beq) alu_op = 3'd1;
      else if (is_ori)      alu_op = 3'd2;
      else if (is_lui)      alu_op = 3'd3;
      else                  alu_op = 3'd0;
    end

    case (cur)
      FETCH: begin
        ir_wr  = 1'b1;
        pc_wr  = 1'b1;
        npc_op = 2'd0;
      end
      DECODE: illegal = !supported;
      EXE: begin
        if (is_beq) begin
          pc_wr  = zero;
          npc_op = 2'd1;
        end else if (is_jr) begin
          pc_wr  = 1'b1;
          npc_op = 2'd3;
        end
      end
      MEM: mem_wr = is_sw;
      WB: begin
        reg_wr = 1'b1;
        if (is_jal) begin
          reg_dst = 2'd2;
          wd_sel  = 2'd2;
          pc_wr   = 1'b1;
          npc_op  = 2'd2;
        end else if (is_lw) begin
          wd_sel = 2'd1;
        end else if (is_add || is_sub) begin
          reg_dst = 2'd1;
        end
      end
      default: ;
    endcase

    // Reset aborts the instruction in flight: no writes of any kind while it is held
    if (!reset) begin
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      ext_op  = 1'b0;
      alu_src = 1'b0;
      alu_op  = 3'd0;
      reg_dst = 2'd0;
      wd_sel  = 2'd0;
      npc_op  = 2'd0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios plus randomized instruction stream checked against a path-based model.
module tb_mc_ctrl;
  localparam int CNT_W = 4;

  localparam int K_ADD = 0, K_SUB = 1, K_JR = 2, K_NOP = 3, K_ORI = 4, K_LW = 5;
  localparam int K_SW = 6, K_BEQ = 7, K_LUI = 8, K_JAL = 9, K_ILL = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_wr, ir_wr, reg_wr, mem_wr, ext_op, alu_src, illegal;
  logic [2:0]       alu_op, state;
  logic [1:0]       reg_dst, wd_sel, npc_op;
  logic [CNT_W-1:0] instr_cnt;

  int               tests = 0;
  int               fails = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr),
    .mem_wr(mem_wr), .ext_op(ext_op), .alu_src(alu_src), .alu_op(alu_op),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .npc_op(npc_op), .state(state),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit legal_enc(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000)
      return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b001000 || fn == 6'b000000;
    return op == 6'b001101 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001111 || op == 6'b000011;
  endfunction

  task automatic encode(input int k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (k)
      K_ADD: begin op = 6'b000000; fn = 6'b100000; end
      K_SUB: begin op = 6'b000000; fn = 6'b100010; end
      K_JR:  begin op = 6'b000000; fn = 6'b001000; end
      K_NOP: begin op = 6'b000000; fn = 6'b000000; end
      K_ORI: op = 6'b001101;
      K_LW:  op = 6'b100011;
      K_SW:  op = 6'b101011;
      K_BEQ: op = 6'b000100;
      K_LUI: op = 6'b001111;
      K_JAL: op = 6'b000011;
      default: begin
        op = ($urandom_range(0, 1) == 0) ? 6'b000000 : 6'($urandom);
        while (legal_enc(op, fn)) fn = 6'($urandom);
      end
    endcase
  endtask

  // Runs one instruction from FETCH, checking every cycle; abort_at >= 0 asserts reset in that step.
  task automatic run_instr(input int k, input bit z, input int wait_cycles, input int abort_at);
    int p[$];
    int idx = 0, step = 0, waited = 0, st;
    logic [5:0] op, fn;
    bit e_pc, e_reg, e_mem, e_ill;
    logic [1:0] e_npc, e_dst, e_wd;
    logic [2:0] e_alu;
    case (k)
      K_LW:         p = '{0, 1, 2, 3, 4};
      K_SW:         p = '{0, 1, 2, 3};
      K_BEQ, K_JR:  p = '{0, 1, 2};
      K_JAL:        p = '{0, 1, 4};
      K_ILL:        p = '{0, 1};
      default:      p = '{0, 1, 2, 4};
    endcase
    encode(k, op, fn);
    opcode = op;
    funct  = fn;
    zero   = z;
    while (idx < p.size()) begin
      st = p[idx];
      mem_ready = (st == 3) ? (waited >= wait_cycles) : 1'($urandom_range(0, 1));
      @(negedge clk);
      e_pc  = (st == 0) || (st == 2 && (k == K_JR || (k == K_BEQ && z))) || (st == 4 && k == K_JAL);
      e_reg = (st == 4);
      e_mem = (st == 3 && k == K_SW);
      e_ill = (st == 1 && k == K_ILL);
      tests++;
      if (state !== 3'(st)) begin fails++; $display("FAIL state k%0d s%0d: got %0d exp %0d", k, step, state, st); end
      tests++;
      if (instr_cnt !== cnt_model) begin fails++; $display("FAIL instr_cnt k%0d s%0d: got %0d exp %0d", k, step, instr_cnt, cnt_model); end
      tests++;
      if ({ir_wr, pc_wr, reg_wr, mem_wr, illegal} !== {st == 0, e_pc, e_reg, e_mem, e_ill}) begin
        fails++;
        $display("FAIL enables(ir,pc,reg,mem,ill) k%0d s%0d: got %05b exp %05b", k, step,
                 {ir_wr, pc_wr, reg_wr, mem_wr, illegal}, {st == 0, e_pc, e_reg, e_mem, e_ill});
      end
      if (e_pc) begin
        e_npc = (st == 0) ? 2'd0 : (k == K_BEQ) ? 2'd1 : (k == K_JR) ? 2'd3 : 2'd2;
        tests++;
        if (npc_op !== e_npc) begin fails++; $display("FAIL npc_op k%0d s%0d: got %0d exp %0d", k, step, npc_op, e_npc); end
      end
      if (st >= 1 && (k == K_LW || k == K_SW || k == K_BEQ || k == K_ORI || k == K_LUI)) begin
        tests++;
        if (ext_op !== (k == K_LW || k == K_SW || k == K_BEQ)) begin
          fails++; $display("FAIL ext_op k%0d s%0d: got %0b", k, step, ext_op);
        end
      end
      if (st == 2 && k != K_JR) begin
        e_alu = (k == K_SUB || k == K_BEQ) ? 3'd1 : (k == K_ORI) ? 3'd2 : (k == K_LUI) ? 3'd3 : 3'd0;
        tests++;
        if ({alu_src, alu_op} !== {(k == K_ORI || k == K_LW || k == K_SW || k == K_LUI), e_alu}) begin
          fails++; $display("FAIL alu k%0d: got src %0b op %0d exp op %0d", k, alu_src, alu_op, e_alu);
        end
      end
      if (st == 4) begin
        e_dst = (k == K_JAL) ? 2'd2 : (k == K_ADD || k == K_SUB || k == K_NOP) ? 2'd1 : 2'd0;
        e_wd  = (k == K_JAL) ? 2'd2 : (k == K_LW) ? 2'd1 : 2'd0;
        tests++;
        if ({reg_dst, wd_sel} !== {e_dst, e_wd}) begin
          fails++; $display("FAIL wb_sel k%0d: got dst %0d wd %0d exp dst %0d wd %0d", k, reg_dst, wd_sel, e_dst, e_wd);
        end
      end
      if (step == abort_at) begin
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({state, reg_wr, mem_wr, pc_wr} !== {3'd0, 3'b000}) begin
          fails++; $display("FAIL abort_immediate: got state %0d reg %0b mem %0b pc %0b exp 0 0 0 0", state, reg_wr, mem_wr, pc_wr);
        end
        @(negedge clk);
        tests++;
        if ({state, reg_wr, instr_cnt} !== {3'd0, 1'b0, {CNT_W{1'b0}}}) begin
          fails++; $display("FAIL abort_hold: got state %0d reg %0b cnt %0d exp 0 0 0", state, reg_wr, instr_cnt);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        cnt_model = '0;
        return;
      end
      @(posedge clk);
      #1;
`ifdef MC_CTRL_MEM_WAIT_EN
      if (st == 3 && !mem_ready) waited++;
      else idx++;
`else
      idx++;
`endif
      step++;
    end
    cnt_model = cnt_model + 1'b1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1 reset = 1'b0;
    opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({state, instr_cnt, ir_wr, pc_wr, reg_wr, mem_wr, illegal} !== {3'd0, {CNT_W{1'b0}}, 5'b0}) begin
        fails++; $display("FAIL reset_hold: got state %0d cnt %0d en %05b exp 0 0 00000", state, instr_cnt,
                          {ir_wr, pc_wr, reg_wr, mem_wr, illegal});
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({state, instr_cnt, ir_wr, pc_wr} !== {3'd0, {CNT_W{1'b0}}, 2'b11}) begin
      fails++; $display("FAIL reset_release: got state %0d cnt %0d ir %0b pc %0b exp 0 0 1 1", state, instr_cnt, ir_wr, pc_wr);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({state, illegal} !== {3'd1, 1'b1}) begin
      fails++; $display("FAIL reset_first_decode: got state %0d illegal %0b exp 1 1", state, illegal);
    end
    @(posedge clk);
    #1;
    cnt_model = cnt_model + 1'b1;
  endtask

  task automatic test_ori_lw;
    logic [CNT_W-1:0] start;
    start = instr_cnt;
    run_instr(K_ORI, 1'b0, 0, -1);
    run_instr(K_LW, 1'b0, 0, -1);
    tests++;
    if (instr_cnt !== start + CNT_W'(2)) begin
      fails++; $display("FAIL ori_lw_count: got %0d exp %0d", instr_cnt, start + CNT_W'(2));
    end
  endtask

  task automatic test_beq;
    run_instr(K_BEQ, 1'b1, 0, -1);
    run_instr(K_BEQ, 1'b0, 0, -1);
  endtask

  task automatic test_jal_jr;
    run_instr(K_JAL, 1'b0, 0, -1);
    run_instr(K_JR, 1'b0, 0, -1);
  endtask

  task automatic test_illegal;
    run_instr(K_ILL, 1'b0, 0, -1);
    run_instr(K_ILL, 1'b1, 0, -1);
    run_instr(K_NOP, 1'b0, 0, -1);
  endtask

  task automatic test_reset_mid;
    run_instr(K_LW, 1'b0, 0, 2);
    run_instr(K_ADD, 1'b0, 0, -1);
  endtask

  task automatic test_mem_wait;
    run_instr(K_SW, 1'b0, 3, -1);
    run_instr(K_LW, 1'b0, 2, -1);
    run_instr(K_SW, 1'b0, 0, -1);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 150; n++)
      run_instr(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1);
  endtask

  initial begin
    test_reset;
    test_ori_lw;
    test_beq;
    test_jal_jr;
    test_illegal;
    test_reset_mid;
    test_mem_wait;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, exp completion before 500000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences each instruction through FETCH/DECODE/EXE/MEM/WB.
- Drives the write enables, mux selects, ALU op and the immediate-extender sign control (ext_op) from the latched opcode/funct.
- Counts retired instructions and flags unsupported encodings.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  6  instr[31:26] from IR (valid from DECODE on)
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU equality flag, valid in EXE
- mem_ready  input  1  data-memory ready (used only with MEM_WAIT_EN)
- pc_wr  output  1  PC write enable
- ir_wr  output  1  IR write enable
- reg_wr  output  1  GRF write enable
- mem_wr  output  1  DM write enable
- ext_op  output  1  1 = sign-extend imm16, 0 = zero-extend
- alu_src  output  1  0 = rt, 1 = extended immediate
- alu_op  output  3  0 add, 1 sub, 2 or, 3 lui-shift
- reg_dst  output  2  0 rt, 1 rd, 2 $31
- wd_sel  output  2  0 ALU, 1 DM, 2 PC+4
- npc_op  output  2  0 PC+4, 1 branch, 2 j-target, 3 rs
- state  output  3  current state, for debug
- illegal  output  1  one-cycle pulse in DECODE on an unsupported encoding
- instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. The state register is the only FSM storage; all control outputs are combinational from state, opcode and funct.
- Reset (reset=0, asynchronous):
  - state=FETCH, instr_cnt=0, illegal=0.
  - All enables 0 in the reset cycle.
  - A reset mid-instruction aborts the instruction with no GRF or DM write after reset asserts.
- FETCH: ir_wr=1, pc_wr=1, npc_op=0. Next state is DECODE.
- Decoded instruction set:
  - R-type (opcode 000000): add (funct 100000), sub (100010), jr (001000); nop = all-zero word, treated as add $0.
  - I-type: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111.
  - J-type: jal 000011.
- Paths:
  - add/sub/ori/lui: F-D-E-WB, 4 cycles.
  - lw: F-D-E-M-WB, 5 cycles.
  - sw: F-D-E-M, 4 cycles; mem_wr=1 in MEM.
  - beq: F-D-E, 3 cycles; pc_wr=zero in EXE, npc_op=1.
  - jr: F-D-E, 3 cycles; pc_wr=1 in EXE, npc_op=3.
  - jal: F-D-WB, 3 cycles; in WB reg_wr=1, reg_dst=2, wd_sel=2, pc_wr=1, npc_op=2.
  - Unsupported: F-D, 2 cycles; illegal=1 in DECODE; no writes; counted as retired.
- Only these next-state edges exist. Any unused state code (5-7) returns to FETCH next cycle with no enables asserted.
- ext_op:
  - 1 for lw, sw, beq; 0 for ori and lui.
  - Held constant across DECODE..WB of one instruction, so the extender output is stable.
- alu_src: 1 for ori, lw, sw, lui; otherwise 0.
- WB settings:
  - R-type: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
- Enables are asserted only in the states listed above; they are 0 in every other state.
- instr_cnt:
  - Increments by 1 on the clock edge that leaves an instruction's final state back to FETCH.
  - Wraps from 2^CNT_W-1 to 0.
  - Never increments twice for one instruction.

Optional Feature:
- Macro: MC_CTRL_MEM_WAIT_EN.
- With the macro defined:
  - MEM holds while mem_ready=0.
  - mem_wr stays asserted while held; the store completes on the edge where mem_ready=1.
  - lw leaves MEM for WB only when mem_ready=1.
  - Reset during a wait returns to FETCH.
- Without the macro: mem_ready is ignored and MEM always lasts exactly 1 cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> state=0, instr_cnt=0, ir_wr=1, pc_wr=1 on the first cycle after release.
- ori then lw: opcode 001101 then 100011 -> state sequences 0,1,2,4 and 0,1,2,3,4. ext_op=0 for ori, 1 for lw. reg_wr=1 only in WB with wd_sel 0 and 1 respectively. instr_cnt=2.
- beq twice: opcode 000100 with zero=1, then zero=0 -> 3 cycles each. pc_wr=1, npc_op=1 in EXE only for zero=1. mem_wr and reg_wr stay 0 throughout.
- jal then jr: opcode 000011; then opcode 000000 with funct 001000 -> jal WB shows reg_dst=2, wd_sel=2, npc_op=2, pc_wr=1. jr EXE shows npc_op=3, pc_wr=1.
- Illegal and reset: opcode 111111 -> illegal pulses 1 cycle, no writes, instr_cnt+1. Separately, assert reset=0 during lw EXE -> state=0 immediately and no WB reg_wr.
- With MC_CTRL_MEM_WAIT_EN: sw with mem_ready=0 for 3 cycles -> state stays 3 and mem_wr=1 for 4 cycles. Return to FETCH follows mem_ready=1.
